coor_gen_axis: RTL and testbench
================================

Name: coor_gen_axis

Overview:
- Parametrised raster coordinate generator with an AXI-Stream master output.
- Emits (y,x) pairs for a ROW x COL frame in row-major order.
- Packs LANES horizontally adjacent coordinates per beat and marks start-of-frame and end-of-row.
- Runs one-shot or continuous.
- Sits upstream of the warp/remap datapath and feeds it source-coordinate requests under backpressure.

Parameters:
- ROW, 480, frame height in rows (>=1)
- COL, 640, frame width in pixels (>=1, multiple of LANES)
- COOR_W, 16, bits per coordinate component (2^COOR_W > max(ROW,COL))
- LANES, 1, coordinates per beat (1,2,4,8)
- CONT, 0, 1 = continuous: restart frame back-to-back while start held high

Ports:
- m_axis_aclk  in  1  clock
- m_axis_aresetn  in  1  asynchronous active-low reset
- start  in  1  level; sampled high in IDLE launches a frame
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  LANES*2*COOR_W  lane i at bits [i*2*COOR_W +: 2*COOR_W] = {y, x+i}
- m_axis_tuser  out  1  first beat of frame (x=0,y=0)
- m_axis_tlast  out  1  last beat of each row
- busy  out  1  FSM in RUN
- frame_done  out  1  one-cycle pulse after final beat handshake
- frame_cnt  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; x=0, y=0; all outputs 0.
- States IDLE, RUN. All outputs registered.
- IDLE: start=1 at clock edge -> RUN, x=0, y=0, tvalid=1 from next cycle (latency 1). start=0 -> stay.
- RUN: tvalid=1 continuously. tdata/tuser/tlast stable until handshake (tvalid&tready). No handshake -> hold.
- On handshake:
  - x<COL-LANES: x+=LANES.
  - Row end, y<ROW-1: x=0, y+=1.
  - Frame end (x=COL-LANES, y=ROW-1): frame_done=1 next cycle, frame_cnt+=1.
    - CONT=1 and start=1: stay RUN, x=y=0, next beat carries tuser with no bubble.
    - Otherwise: IDLE, tvalid=0 next cycle.
- tuser = (x==0 && y==0). tlast = (x==COL-LANES). ROW=1, COL=LANES: every beat has tuser=tlast=1.
- start deasserted mid-frame: no effect; frame completes.
- start high in IDLE on the cycle after frame_done: new frame begins (one idle cycle gap when CONT=0).
- Reset mid-frame: tvalid drops immediately (async); partial frame discarded; frame_cnt cleared.
- Arithmetic: x,y are COOR_W unsigned. Lane x+i never exceeds COL-1. No overflow possible under the parameter constraints.
- Elaboration check: COL%LANES!=0 or 2^COOR_W<=max(ROW,COL) -> fatal.

Optional Feature:
- COOR_GEN_ROI_EN defined:
  - Adds inputs roi_x0, roi_y0, roi_w, roi_h (COOR_W each), latched when IDLE->RUN.
  - Raster covers x in [roi_x0, roi_x0+roi_w), y in [roi_y0, roi_y0+roi_h). tuser on first ROI beat, tlast at ROI row end.
  - roi_w must be a multiple of LANES.
  - roi_w=0 or roi_h=0, or region exceeding COL/ROW: no beats; frame_done pulses 1 cycle after launch; frame_cnt unchanged.
  - CONT restart re-latches the ROI.
- Not defined: ports absent; full-frame raster only.

Decomposition:
- Package coor_gen_pkg:
  - COOR_W-based coordinate typedef.
  - Packed {y,x} pair struct.
  - Lane-packing function.
  - State enum (IDLE, RUN).
- Sub-module coor_gen_cnt: x/y raster counter with step LANES, programmable origin/extent, and row_end/frame_end flags. Top holds the FSM, AXIS register stage and frame counter.

Test Plan:
- ROW=4, COL=6, LANES=1, tready=1; start pulse -> 24 beats; beat0 {0,0} tuser=1; tlast on x=5 beats; last {3,5}; frame_done one cycle later; frame_cnt=1.
- Same config, tready 1,1,1,0,0,1,0,1... -> tdata held stable across stalls; sequence identical to the no-stall run; no drops or duplicates.
- LANES=2, COL=6 -> 12 beats/frame; beat0 lanes {0,0},{0,1}; beat2 lanes {0,4},{0,5} with tlast=1.
- CONT=1, start held high, tready=1 -> frames back-to-back with no bubble; tuser every 24 beats; frame_cnt 1,2,3.
- Assert reset mid-frame at beat 10 -> tvalid=0 immediately; after release plus start, frame restarts at {0,0}; frame_cnt=0.
- COOR_GEN_ROI_EN: roi (x0=2, y0=1, w=2, h=2) -> beats {1,2},{1,3}tlast,{2,2},{2,3}tlast; w=0 -> zero beats, frame_done pulse, frame_cnt unchanged.

Source files
------------

// File: rtl/coor_gen_pkg.sv
// Shared types and helpers for the coor_gen_axis raster coordinate generator.
package coor_gen_pkg;

  localparam int COOR_W_MAX = 32;

  typedef logic [COOR_W_MAX-1:0] coor_t;

  typedef struct packed {
    coor_t y;
    coor_t x;
  } coor_pair_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Builds lane `lane` of a beat as {y, x+lane}, both trimmed to w bits and
  // packed into the low 2*w bits of the result.
  function automatic logic [2*COOR_W_MAX-1:0] lane_word(input coor_t       y,
                                                        input coor_t       x,
                                                        input int unsigned lane,
                                                        input int unsigned w);
    coor_t      mask;
    coor_pair_t p;
    mask = (w >= COOR_W_MAX) ? '1 : ((coor_t'(1) << w) - coor_t'(1));
    p.y  = y & mask;
    p.x  = (x + coor_t'(lane)) & mask;
    return ({{COOR_W_MAX{1'b0}}, p.y} << w) | {{COOR_W_MAX{1'b0}}, p.x};
  endfunction

endpackage

// File: rtl/coor_gen_cnt.sv
// Raster x/y counter stepping LANES pixels per beat over a latched region.
// Outputs describe the position that becomes current after this clock edge.
module coor_gen_cnt
  import coor_gen_pkg::*;
#(
  parameter int COOR_W = 16,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [COOR_W-1:0] x0,
  input  logic [COOR_W-1:0] y0,
  input  logic [COOR_W-1:0] w,
  input  logic [COOR_W-1:0] h,
  output logic [COOR_W-1:0] nxt_x,
  output logic [COOR_W-1:0] nxt_y,
  output logic              nxt_row_end,
  output logic              nxt_frame_end
);

  typedef logic [COOR_W-1:0] cw_t;

  cw_t x_q, y_q, x0_q, x_last_q, y_last_q;
  cw_t x0_d, x_last_d, y_last_d;

  // NOTE: every variable gets a default before the branches so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    x0_d     = x0_q;
    x_last_d = x_last_q;
    y_last_d = y_last_q;
    nxt_x    = x_q;
    nxt_y    = y_q;
    if (load) begin
      x0_d     = x0;
      x_last_d = x0 + w - cw_t'(LANES);
      y_last_d = y0 + h - cw_t'(1);
      nxt_x    = x0;
      nxt_y    = y0;
    end else if (step) begin
      if (x_q == x_last_q) begin
        nxt_x = x0_q;
        nxt_y = y_q + cw_t'(1);
      end else begin
        nxt_x = x_q + cw_t'(LANES);
      end
    end
  end

  assign nxt_row_end   = (nxt_x == x_last_d);
  assign nxt_frame_end = nxt_row_end && (nxt_y == y_last_d);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
    end else begin
      x_q      <= nxt_x;
      y_q      <= nxt_y;
      x0_q     <= x0_d;
      x_last_q <= x_last_d;
      y_last_q <= y_last_d;
    end
  end

endmodule

// File: rtl/coor_gen_axis.sv
// Raster (y,x) coordinate generator with registered AXI-Stream master output.
// Optional region-of-interest raster when COOR_GEN_ROI_EN is defined.
module coor_gen_axis
  import coor_gen_pkg::*;
#(
  parameter int ROW    = 480,
  parameter int COL    = 640,
  parameter int COOR_W = 16,
  parameter int LANES  = 1,
  parameter int CONT   = 0
) (
  input  logic                        m_axis_aclk,
  input  logic                        m_axis_aresetn,
  input  logic                        start,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [LANES*2*COOR_W-1:0]   m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic                        frame_done,
`ifdef COOR_GEN_ROI_EN
  input  logic [COOR_W-1:0]           roi_x0,
  input  logic [COOR_W-1:0]           roi_y0,
  input  logic [COOR_W-1:0]           roi_w,
  input  logic [COOR_W-1:0]           roi_h,
`endif
  output logic [15:0]                 frame_cnt
);

  typedef logic [COOR_W-1:0] cw_t;
  localparam int PAIR_W  = 2 * COOR_W;
  localparam int DIM_MAX = (ROW > COL) ? ROW : COL;

  if ((COL % LANES) != 0 || (DIM_MAX >> COOR_W) != 0 || COOR_W > COOR_W_MAX ||
      ROW < 1 || COL < 1) begin : g_bad_cfg
    $fatal(1, "coor_gen_axis: illegal ROW/COL/COOR_W/LANES combination");
  end

  cw_t    org_x, org_y, ext_w, ext_h;
  logic   roi_ok;

`ifdef COOR_GEN_ROI_EN
  logic [COOR_W:0] x_span, y_span;
  assign org_x  = roi_x0;
  assign org_y  = roi_y0;
  assign ext_w  = roi_w;
  assign ext_h  = roi_h;
  assign x_span = {1'b0, roi_x0} + {1'b0, roi_w};
  assign y_span = {1'b0, roi_y0} + {1'b0, roi_h};
  // An empty, ragged or out-of-frame region launches no beats at all.
  assign roi_ok = (roi_w != '0) && (roi_h != '0) && ((roi_w % cw_t'(LANES)) == '0) &&
                  (x_span <= (COOR_W+1)'(COL)) && (y_span <= (COOR_W+1)'(ROW));
`else
  assign org_x  = '0;
  assign org_y  = '0;
  assign ext_w  = cw_t'(COL);
  assign ext_h  = cw_t'(ROW);
  assign roi_ok = 1'b1;
`endif

  state_e state_q, state_d;
  logic   load, step, done_d, hs, last_q;
  cw_t    nxt_x, nxt_y;
  logic   nxt_row_end, nxt_frame_end;
  logic [LANES*2*COOR_W-1:0] tdata_d;

  coor_gen_cnt #(
    .COOR_W (COOR_W),
    .LANES  (LANES)
  ) u_cnt (
    .clk           (m_axis_aclk),
    .rst_n         (m_axis_aresetn),
    .load          (load),
    .step          (step),
    .x0            (org_x),
    .y0            (org_y),
    .w             (ext_w),
    .h             (ext_h),
    .nxt_x         (nxt_x),
    .nxt_y         (nxt_y),
    .nxt_row_end   (nxt_row_end),
    .nxt_frame_end (nxt_frame_end)
  );

  assign m_axis_tvalid = (state_q == RUN);
  assign busy          = (state_q == RUN);
  assign hs            = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (roi_ok) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (last_q) begin
            done_d = 1'b1;
            // Continuous mode reloads the origin in the same edge: no bubble.
            if (CONT != 0 && start && roi_ok) load    = 1'b1;
            else                              state_d = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tdata_d = '0;
    for (int i = 0; i < LANES; i++) begin
      tdata_d[i*PAIR_W +: PAIR_W] =
        PAIR_W'(lane_word(coor_t'(nxt_y), coor_t'(nxt_x), int'(i), COOR_W));
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q      <= IDLE;
      m_axis_tdata <= '0;
      m_axis_tuser <= 1'b0;
      m_axis_tlast <= 1'b0;
      last_q       <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      frame_done <= done_d;
      if (hs && last_q) frame_cnt <= frame_cnt + 16'd1;
      if (load || step) begin
        m_axis_tdata <= tdata_d;
        m_axis_tuser <= load;
        m_axis_tlast <= nxt_row_end;
        last_q       <= nxt_frame_end;
      end
    end
  end

endmodule

// File: tb/tb_coor_gen_axis.sv
// Self-checking bench for coor_gen_axis: three instances (LANES=1, LANES=2, CONT=1)
// checked every cycle against a queue-based raster model plus literal spot checks.
module tb_coor_gen_axis;

  localparam int ROW = 4;
  localparam int COL = 6;
  localparam int CW  = 16;
  localparam int N   = 3;
  localparam int QD  = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [N];
  logic start [N];
  logic tready[N];

`ifdef COOR_GEN_ROI_EN
  logic [CW-1:0] roi_x0 = '0, roi_y0 = '0, roi_w = CW'(COL), roi_h = CW'(ROW);
`endif

  logic        a_tv, a_tu, a_tl, a_bz, a_fd;  logic [31:0] a_td; logic [15:0] a_fc;
  logic        b_tv, b_tu, b_tl, b_bz, b_fd;  logic [63:0] b_td; logic [15:0] b_fc;
  logic        c_tv, c_tu, c_tl, c_bz, c_fd;  logic [31:0] c_td; logic [15:0] c_fc;

  coor_gen_axis #(.ROW(ROW), .COL(COL), .COOR_W(CW), .LANES(1), .CONT(0)) dut_a (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n[0]), .start(start[0]),
    .m_axis_tvalid(a_tv), .m_axis_tready(tready[0]), .m_axis_tdata(a_td),
    .m_axis_tuser(a_tu), .m_axis_tlast(a_tl), .busy(a_bz), .frame_done(a_fd),
`ifdef COOR_GEN_ROI_EN
    .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
`endif
    .frame_cnt(a_fc));

  coor_gen_axis #(.ROW(ROW), .COL(COL), .COOR_W(CW), .LANES(2), .CONT(0)) dut_b (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n[1]), .start(start[1]),
    .m_axis_tvalid(b_tv), .m_axis_tready(tready[1]), .m_axis_tdata(b_td),
    .m_axis_tuser(b_tu), .m_axis_tlast(b_tl), .busy(b_bz), .frame_done(b_fd),
`ifdef COOR_GEN_ROI_EN
    .roi_x0(16'd0), .roi_y0(16'd0), .roi_w(16'd6), .roi_h(16'd4),
`endif
    .frame_cnt(b_fc));

  coor_gen_axis #(.ROW(ROW), .COL(COL), .COOR_W(CW), .LANES(1), .CONT(1)) dut_c (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n[2]), .start(start[2]),
    .m_axis_tvalid(c_tv), .m_axis_tready(tready[2]), .m_axis_tdata(c_td),
    .m_axis_tuser(c_tu), .m_axis_tlast(c_tl), .busy(c_bz), .frame_done(c_fd),
`ifdef COOR_GEN_ROI_EN
    .roi_x0(16'd0), .roi_y0(16'd0), .roi_w(16'd6), .roi_h(16'd4),
`endif
    .frame_cnt(c_fc));

  logic        tv[N], tu[N], tla[N], bz[N], fd[N];
  logic [63:0] td[N];
  logic [15:0] fc[N];

  always_comb begin
    tv[0] = a_tv; tu[0] = a_tu; tla[0] = a_tl; bz[0] = a_bz; fd[0] = a_fd; td[0] = {32'd0, a_td}; fc[0] = a_fc;
    tv[1] = b_tv; tu[1] = b_tu; tla[1] = b_tl; bz[1] = b_bz; fd[1] = b_fd; td[1] = b_td;           fc[1] = b_fc;
    tv[2] = c_tv; tu[2] = c_tu; tla[2] = c_tl; bz[2] = c_bz; fd[2] = c_fd; td[2] = {32'd0, c_td}; fc[2] = c_fc;
  end

  // Model: expected beats per instance, frame completions and done pulses.
  logic [63:0] q_data [N][QD];
  bit          q_user [N][QD];
  bit          q_last [N][QD];
  bit          q_flast[N][QD];
  int          hd[N], q_wr[N], exp_cnt[N];
  bit          exp_fd[N], inject_done[N];

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Raster over [x0,x0+w) x [y0,y0+h), lanes adjacent pixels per beat.
  task automatic push_frame(input int i, input int x0, input int y0, input int w, input int h, input int lanes);
    logic [63:0] d;
    for (int y = y0; y < y0 + h; y++) begin
      for (int x = x0; x < x0 + w; x += lanes) begin
        d = '0;
        for (int l = 0; l < lanes; l++) d[l*32 +: 32] = {16'(y), 16'(x + l)};
        q_data [i][q_wr[i] % QD] = d;
        q_user [i][q_wr[i] % QD] = (x == x0) && (y == y0);
        q_last [i][q_wr[i] % QD] = (x == x0 + w - lanes);
        q_flast[i][q_wr[i] % QD] = (x == x0 + w - lanes) && (y == y0 + h - 1);
        q_wr[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    bit pop_last;
    for (int i = 0; i < N; i++) begin
      pop_last = 1'b0;
      if (!rst_n[i]) begin
        hd[i] = 0; q_wr[i] = 0; exp_cnt[i] = 0; exp_fd[i] = 1'b0; inject_done[i] = 1'b0;
      end
      check(bz[i] == tv[i], $sformatf("dut%0d.busy", i), 64'(bz[i]), 64'(tv[i]));
      check(fd[i] == exp_fd[i], $sformatf("dut%0d.frame_done", i), 64'(fd[i]), 64'(exp_fd[i]));
      check(fc[i] == 16'(exp_cnt[i]), $sformatf("dut%0d.frame_cnt", i), 64'(fc[i]), 64'(exp_cnt[i]));
      if (tv[i]) begin
        check(q_wr[i] > hd[i], $sformatf("dut%0d.beat_expected", i), 64'(q_wr[i] - hd[i]), 64'd1);
        if (q_wr[i] > hd[i]) begin
          check(td[i] == q_data[i][hd[i] % QD], $sformatf("dut%0d.tdata", i), td[i], q_data[i][hd[i] % QD]);
          check(tu[i] == q_user[i][hd[i] % QD], $sformatf("dut%0d.tuser", i), 64'(tu[i]), 64'(q_user[i][hd[i] % QD]));
          check(tla[i] == q_last[i][hd[i] % QD], $sformatf("dut%0d.tlast", i), 64'(tla[i]), 64'(q_last[i][hd[i] % QD]));
          if (tready[i]) begin
            pop_last = q_flast[i][hd[i] % QD];
            hd[i]++;
          end
        end
      end
      exp_fd[i] = pop_last || inject_done[i];
      inject_done[i] = 1'b0;
      if (pop_last) exp_cnt[i]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sampling edge; returns with the first beat on the bus.
  task automatic launch(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic drain(input int i, input int budget, input string name);
    for (int n = 0; n < budget && hd[i] != q_wr[i]; n++) tick();
    check(hd[i] == q_wr[i], name, 64'(hd[i]), 64'(q_wr[i]));
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat[8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; tready[i] = 1'b1;
    end
    repeat (3) tick();
    check(a_tv == 1'b0 && a_tu == 1'b0 && a_tl == 1'b0, "reset.ctrl", {61'd0, a_tv, a_tu, a_tl}, 64'd0);
    check(a_td == 32'd0, "reset.tdata", 64'(a_td), 64'd0);
    check(a_fc == 16'd0 && a_fd == 1'b0, "reset.cnt", {47'd0, a_fd, a_fc}, 64'd0);
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    repeat (2) tick();

    // Full frame, no backpressure: exactly 24 beats back-to-back.
    push_frame(0, 0, 0, COL, ROW, 1);
    launch(0);
    check(a_tv == 1'b1, "a.latency", 64'(a_tv), 64'd1);
    check(a_td == 32'h0000_0000 && a_tu == 1'b1, "a.beat0", {31'd0, a_tu, a_td}, {31'd0, 1'b1, 32'd0});
    for (int n = 0; n < 24; n++) begin
      if (n == 5)  check(a_tl == 1'b1, "a.tlast_x5", 64'(a_tl), 64'd1);
      if (n == 23) check(a_td == 32'h0003_0005 && a_tl == 1'b1, "a.beat23", {31'd0, a_tl, a_td}, {31'd1, 32'h0003_0005});
      tick();
    end
    check(hd[0] == q_wr[0] && a_tv == 1'b0, "a.24_beats", {31'd0, a_tv, 32'(q_wr[0] - hd[0])}, 64'd0);
    check(a_fd == 1'b1 && a_fc == 16'd1, "a.done1", {47'd0, a_fd, a_fc}, {47'd0, 1'b1, 16'd1});
    tick();

    // Same frame under a stall pattern.
    push_frame(0, 0, 0, COL, ROW, 1);
    launch(0);
    for (int n = 0; n < 200 && hd[0] != q_wr[0]; n++) begin
      tready[0] = pat[n % 8];
      tick();
    end
    tready[0] = 1'b1;
    drain(0, 10, "a.stall_drain");
    check(a_fc == 16'd2, "a.cnt2", 64'(a_fc), 64'd2);

    // Reset mid-frame after 10 beats.
    push_frame(0, 0, 0, COL, ROW, 1);
    launch(0);
    repeat (10) tick();
    rst_n[0] = 1'b0;
    #1;
    check(a_tv == 1'b0, "a.reset_tvalid", 64'(a_tv), 64'd0);
    check(a_fc == 16'd0, "a.reset_cnt", 64'(a_fc), 64'd0);
    repeat (2) tick();
    rst_n[0] = 1'b1;
    tick();
    push_frame(0, 0, 0, COL, ROW, 1);
    launch(0);
    check(a_td == 32'h0 && a_tu == 1'b1 && a_tv == 1'b1, "a.restart", {30'd0, a_tv, a_tu, a_td}, {30'd0, 2'b11, 32'd0});
    drain(0, 60, "a.restart_drain");
    check(a_fc == 16'd1, "a.restart_cnt", 64'(a_fc), 64'd1);

    // Two lanes per beat: 12 beats per frame.
    push_frame(1, 0, 0, COL, ROW, 2);
    launch(1);
    check(b_td == 64'h0000_0001_0000_0000 && b_tu == 1'b1, "b.beat0", b_td, 64'h0000_0001_0000_0000);
    repeat (2) tick();
    check(b_td == 64'h0000_0005_0000_0004 && b_tl == 1'b1, "b.beat2", b_td, 64'h0000_0005_0000_0004);
    repeat (10) tick();
    check(hd[1] == q_wr[1] && b_tv == 1'b0, "b.12_beats", {31'd0, b_tv, 32'(q_wr[1] - hd[1])}, 64'd0);
    check(b_fd == 1'b1 && b_fc == 16'd1, "b.done1", {47'd0, b_fd, b_fc}, {47'd0, 1'b1, 16'd1});
    tick();

    // Continuous mode: three frames with no bubble, start dropped in frame 3.
    for (int f = 0; f < 3; f++) push_frame(2, 0, 0, COL, ROW, 1);
    start[2] = 1'b1;
    tick();
    for (int n = 0; n < 72; n++) begin
      if (n == 24 || n == 48) check(c_tu == 1'b1 && c_td == 32'd0, $sformatf("c.tuser_beat%0d", n), {31'd0, c_tu, c_td}, {31'd0, 1'b1, 32'd0});
      if (n == 55) start[2] = 1'b0;
      tick();
    end
    check(hd[2] == q_wr[2] && c_tv == 1'b0, "c.no_bubble", {31'd0, c_tv, 32'(q_wr[2] - hd[2])}, 64'd0);
    check(c_fc == 16'd3 && c_fd == 1'b1, "c.cnt3", {47'd0, c_fd, c_fc}, {47'd0, 1'b1, 16'd3});
    tick();

`ifdef COOR_GEN_ROI_EN
    roi_x0 = 16'd2; roi_y0 = 16'd1; roi_w = 16'd2; roi_h = 16'd2;
    push_frame(0, 2, 1, 2, 2, 1);
    launch(0);
    check(a_td == 32'h0001_0002 && a_tu == 1'b1 && a_tl == 1'b0, "roi.beat0", {30'd0, a_tu, a_tl, a_td}, {30'd0, 2'b10, 32'h0001_0002});
    tick();
    check(a_td == 32'h0001_0003 && a_tl == 1'b1, "roi.beat1", {31'd0, a_tl, a_td}, {31'd1, 32'h0001_0003});
    tick();
    check(a_td == 32'h0002_0002 && a_tu == 1'b0, "roi.beat2", {31'd0, a_tu, a_td}, {31'd0, 32'h0002_0002});
    tick();
    check(a_td == 32'h0002_0003 && a_tl == 1'b1, "roi.beat3", {31'd0, a_tl, a_td}, {31'd1, 32'h0002_0003});
    drain(0, 10, "roi.drain");
    check(a_fc == 16'd2, "roi.cnt", 64'(a_fc), 64'd2);
    roi_w = 16'd0;
    inject_done[0] = 1'b1;
    launch(0);
    check(a_fd == 1'b1 && a_tv == 1'b0 && a_fc == 16'd2, "roi.empty", {46'd0, a_fd, a_tv, a_fc}, {46'd0, 2'b10, 16'd2});
    repeat (3) tick();
    roi_x0 = 16'd0; roi_y0 = 16'd0; roi_w = 16'd6; roi_h = 16'd4;
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
